// File: rtl/aes_final_round_pipe_pkg.sv
// Shared AES definitions: job type, S-box tables and ShiftRows permutations.
// Byte i of a 128-bit state is bits [127-8i -: 8]; column-major, byte 4c+r.
package sysdef;

   typedef enum logic [1:0] {
      INVALID = 2'd0,
      ENCRYPT = 2'd1,
      DECRYPT = 2'd2
   } job_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   // Inverse table derived from the forward one so the two can never disagree.
   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      logic [7:0] r;
      logic [7:0] idx;
      r = '0;
      for (int unsigned i = 0; i < 256; i++) begin
         idx = 8'(i);
         if (SBOX[idx] == y) r = idx;
      end
      return r;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [15:0][7:0] a;
      logic [15:0][7:0] r;
      logic [3:0]       k;
      a = s;
      r = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         k    = 4'(i);
         r[k] = sbox(a[k]);
      end
      return r;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [15:0][7:0] a;
      logic [15:0][7:0] r;
      logic [3:0]       k;
      a = s;
      r = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         k    = 4'(i);
         r[k] = inv_sbox(a[k]);
      end
      return r;
   endfunction

   // Packed element [15-i] holds byte i; row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [15:0][7:0] a;
      logic [15:0][7:0] o;
      a = s;
      o = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            o[4'(15 - (4*c + r))] = a[4'(15 - (4*((c + r) % 4) + r))];
      return o;
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [15:0][7:0] a;
      logic [15:0][7:0] o;
      a = s;
      o = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            o[4'(15 - (4*c + r))] = a[4'(15 - (4*((c + 4 - r) % 4) + r))];
      return o;
   endfunction

endpackage

// File: rtl/aes_final_round_dp.sv
// Final-round datapath: separate encrypt/decrypt S-box layers with operand
// gating, 1+SBOX_STAGES register stages, AddRoundKey after the last stage.
module aes_final_round_dp
   import sysdef::*;
#(
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned SBOX_STAGES = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  job_t             in_type,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [127:0]     in_state,
   input  logic [127:0]     in_key,
   input  logic [127:0]     in_inv_key,
   output logic             out_valid,
   output job_t             out_type,
   output logic [TAG_W-1:0] out_tag,
   output logic [127:0]     out_data,
   output logic             busy
);

   typedef struct packed {
      logic             valid;
      job_t             typ;
      logic [TAG_W-1:0] tag;
      logic [127:0]     enc_sb;
      logic [127:0]     dec_sb;
      logic [127:0]     enc_key;
      logic [127:0]     dec_key;
   } stage_t;

   logic         enc_sel;
   logic         dec_sel;
   logic [127:0] enc_state;
   logic [127:0] dec_state;
   stage_t       head;
   stage_t       last;
   logic [SBOX_STAGES:0] vld;

   assign enc_sel = load && (in_type == ENCRYPT);
   assign dec_sel = load && (in_type == DECRYPT);

   // The idle direction is fed zeros so it never toggles on live data.
   assign enc_state = enc_sel ? in_state : '0;
   assign dec_state = dec_sel ? in_state : '0;

   always_comb begin
      head         = '0;
      head.valid   = load;
      head.typ     = load ? in_type : INVALID;
      head.tag     = load ? in_tag  : '0;
      head.enc_sb  = shift_rows(sub_bytes(enc_state));
      head.dec_sb  = inv_sub_bytes(inv_shift_rows(dec_state));
      head.enc_key = enc_sel ? in_key     : '0;
      head.dec_key = dec_sel ? in_inv_key : '0;
   end

   for (genvar g = 0; g <= SBOX_STAGES; g++) begin : g_pipe
      stage_t r;
      if (g == 0) begin : g_first
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r <= '0;
            else        r <= head;
         end
      end else begin : g_next
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r <= '0;
            else        r <= g_pipe[g-1].r;
         end
      end
      assign vld[g] = r.valid;
   end

   assign last      = g_pipe[SBOX_STAGES].r;
   assign out_valid = last.valid;
   assign out_type  = last.typ;
   assign out_tag   = last.tag;
   assign busy      = |vld;

   always_comb begin
      out_data = '0;
      case (last.typ)
         ENCRYPT: out_data = last.enc_sb ^ last.enc_key;
         DECRYPT: out_data = last.dec_sb ^ last.dec_key;
         default: out_data = '0;
      endcase
   end

endmodule

// File: rtl/aes_final_round_pipe.sv
// Stallable final AES round: non-stalling datapath, credit-based input flow
// control and an output FIFO with fall-through bypass.
module aes_final_round_pipe
   import sysdef::*;
#(
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned SBOX_STAGES = 0,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  job_t             in_type,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [127:0]     in_state,
   input  logic [127:0]     in_key,
   input  logic [127:0]     in_inv_key,
   output logic             out_valid,
   input  logic             out_ready,
   output job_t             out_type,
   output logic [TAG_W-1:0] out_tag,
   output logic [127:0]     out_data,
   output logic             busy
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   if (SBOX_STAGES > 2) begin : g_bad_stages
      $error("aes_final_round_pipe: SBOX_STAGES must be 0..2");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("aes_final_round_pipe: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef struct packed {
      job_t             typ;
      logic [TAG_W-1:0] tag;
      logic [127:0]     data;
   } entry_t;

   logic             accept;
   logic             dp_valid;
   job_t             dp_type;
   logic [TAG_W-1:0] dp_tag;
   logic [127:0]     dp_data;
   logic             dp_busy;

   entry_t           mem [FIFO_DEPTH];
   entry_t           fifo_head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] occ;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic             pop;

   assign accept = in_valid && in_ready;

   aes_final_round_dp #(
      .TAG_W      (TAG_W),
      .SBOX_STAGES(SBOX_STAGES)
   ) u_dp (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .in_type   (in_type),
      .in_tag    (in_tag),
      .in_state  (in_state),
      .in_key    (in_key),
      .in_inv_key(in_inv_key),
      .out_valid (dp_valid),
      .out_type  (dp_type),
      .out_tag   (dp_tag),
      .out_data  (dp_data),
      .busy      (dp_busy)
   );

   assign fifo_empty = (fifo_count == '0);
   assign fifo_head  = mem[rd_ptr];
   assign pop        = out_valid && out_ready;
   assign fifo_pop   = !fifo_empty && out_ready;
   // A result bypasses storage only when the FIFO is empty and it leaves now.
   assign fifo_push  = dp_valid && !(fifo_empty && out_ready);

   always_comb begin
      out_valid = 1'b0;
      out_type  = INVALID;
      out_tag   = '0;
      out_data  = '0;
      if (!fifo_empty) begin
         out_valid = 1'b1;
         out_type  = fifo_head.typ;
         out_tag   = fifo_head.tag;
         out_data  = fifo_head.data;
      end else if (dp_valid) begin
         out_valid = 1'b1;
         out_type  = dp_type;
         out_tag   = dp_tag;
         out_data  = dp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) mem[wr_ptr] <= '{typ: dp_type, tag: dp_tag, data: dp_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         occ        <= '0;
      end else begin
         if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         // Occupancy covers both in-flight and buffered blocks.
         case ({accept, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   assign in_ready = (occ < CNT_W'(FIFO_DEPTH));
   assign busy     = dp_busy || !fifo_empty;

endmodule

// File: doc/aes_final_round_pipe.md
Name: aes_final_round_pipe

Overview:
Parametrised final AES round (encrypt: SubBytes→ShiftRows→AddRoundKey; decrypt: InvShiftRows→InvSubBytes→AddRoundKey) with valid/ready handshakes, a configurable S-box pipeline depth and an output skid FIFO. Each block carries a job tag, so completions can be matched upstream. Sits at the tail of the round pipeline and replaces the single-register, non-stallable last-round stage. It feeds the output formatter, which may back-pressure.

Parameters:
TAG_W, 4, width of the opaque job tag carried alongside each block
SBOX_STAGES, 0, extra register stages between the S-box layer and AddRoundKey (0..2)
FIFO_DEPTH, 2, output buffer entries (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input block present
in_ready  out  1  stage can accept a block this cycle
in_type  in  job_t  INVALID/ENCRYPT/DECRYPT
in_tag  in  TAG_W  job tag
in_state  in  128  round state; byte i = bits [127-8i -: 8], column-major (byte 4c+r)
in_key  in  128  encrypt round key (round 10/12/14)
in_inv_key  in  128  decrypt round key (round 0)
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_type  out  job_t  type of the result
out_tag  out  TAG_W  tag of the result
out_data  out  128  result block
busy  out  1  any block in the pipe or FIFO

Behaviour:
- Reset: asynchronous on rst_n, active-low; clk rising edge. All pipe valids = 0, FIFO empty; out_valid=0, out_type=INVALID, out_tag=0, out_data=0, busy=0, in_ready=1 after reset release.
- Accept when in_valid && in_ready. Key for the selected direction is sampled with the block; key inputs are ignored otherwise.
- Operand gating: the inactive datapath sees an all-zero state and key (side-channel/power requirement); no shared S-box.
- Pipe is non-stalling: latency from accept to FIFO write = 1+SBOX_STAGES cycles. With the FIFO empty and out_ready=1, out_valid rises 1+SBOX_STAGES cycles after accept (the FIFO has a fall-through bypass).
- Flow control by credit: in_ready = (fifo_count + inflight) < FIFO_DEPTH, computed from registered counters only (no combinational path from out_ready to in_ready). Same-cycle pop frees credit the next cycle.
- in_type INVALID with in_valid=1: accepted, travels the pipe, emerges with out_type=INVALID, out_data=128'h0, tag preserved.
- out_valid/out_type/out_tag/out_data stay stable while out_valid && !out_ready.
- Simultaneous push and pop on a full FIFO: both occur, and count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Strict in-order delivery; no reordering between ENCRYPT and DECRYPT.
- busy = |pipe valids || fifo_count != 0.
- Reset mid-operation: in-flight and buffered blocks are discarded silently, and outputs return to reset values immediately.
- Illegal SBOX_STAGES or FIFO_DEPTH: elaboration-time $error.

Decomposition:
- Shared package (sysdef): job_t {INVALID, ENCRYPT, DECRYPT}; S-box and inverse S-box tables as functions; shift_rows/inv_shift_rows functions.
- One sub-module: aes_final_round_dp. It is the purely combinational+SBOX_STAGES registered datapath with tag/type sideband. The top holds the credit counter and the FIFO.

Test Plan:
- ENCRYPT, state=0, key=0 → out_data=128'h6363…63 (all bytes 63), out_type=ENCRYPT, tag echoed. Latency 1+SBOX_STAGES with out_ready=1.
- ENCRYPT, state=0 except byte1=8'h01, key=0 → byte13 (bits[23:16])=7c, all other bytes 63. This checks the ShiftRows direction. A DECRYPT of that result with inv_key=0 → the original state.
- DECRYPT, state=all 63, inv_key=128'hFF…FF → out_data=128'hFF…FF. ENCRYPT state=0, key=all FF → all bytes 9c.
- Back-pressure: hold out_ready=0 and stream 8 blocks. in_ready deasserts after FIFO_DEPTH accepts. Outputs are stable while stalled. Releasing out_ready yields all 8 blocks in order with correct tags and no loss or duplication.
- in_valid with INVALID type between two ENCRYPT blocks → three outputs in order; the middle one has out_type=INVALID, out_data=0.
- Assert rst_n low while the FIFO is full and the pipe is occupied → out_valid=0 and busy=0 in the same cycle. After release, in_ready=1 and the first new block emerges correctly.
